// File: rtl/serial_op_sequencer.sv
// serial_op_sequencer
// Frames one serial-in / parallel-op / serial-out operation for a datapath
// wrapper: LOAD shifts operands in, COMPUTE enables the core, CAPTURE loads
// the result register, UNLOAD shifts the result out, then done pulses.
// Optional feature macro: SEQ_ABORT_EN adds an abort input and an aborted
// one-cycle status pulse; without it only resetn can end a frame early.
// All outputs are flops loaded from the next-state decode, so there is no
// combinational path from any input to any output.

module serial_op_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       busy,
    output logic       done,
    output logic       in_shift_en,
    output logic       dp_enable,
    output logic       out_load,
    output logic       out_shift_en,
    output logic [2:0] phase
);

    // The counter has to reach the longest phase length. For the usual case
    // COMPUTE_CYCLES <= DATA_WIDTH this is clog2(DATA_WIDTH+1) bits.
    localparam int CNT_MAX = (DATA_WIDTH > COMPUTE_CYCLES) ? DATA_WIDTH : COMPUTE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_e;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_nxt_s;
    logic             aborted_nxt_s;

    logic             busy_r;
    logic             done_r;
    logic             in_shift_en_r;
    logic             dp_enable_r;
    logic             out_load_r;
    logic             out_shift_en_r;
    logic             aborted_r;

    // Next-state and phase-counter decode; the counter restarts at zero on
    // every state change and only advances while a phase is still running.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = CNT_ZERO;
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_r == FRAME_LAST) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_r == COMPUTE_LAST) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (cnt_r == FRAME_LAST) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                // Encodings 5..7 are unreachable in normal operation; recover quietly.
                state_nxt_s = ST_IDLE;
            end
        endcase

`ifdef SEQ_ABORT_EN
        // Abort overrides whatever transition the phase logic chose, including
        // the final UNLOAD->IDLE step, so a frame aborted there never reports done.
        if (abort && (state_r != ST_IDLE)) begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            done_nxt_s    = 1'b0;
            aborted_nxt_s = 1'b1;
        end else begin
            aborted_nxt_s = 1'b0;
        end
`endif
    end

    // FSM state, counter and all registered outputs; outputs are loaded from
    // the next state so they line up with the state register cycle for cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            in_shift_en_r  <= 1'b0;
            dp_enable_r    <= 1'b0;
            out_load_r     <= 1'b0;
            out_shift_en_r <= 1'b0;
            aborted_r      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            done_r         <= done_nxt_s;
            in_shift_en_r  <= (state_nxt_s == ST_LOAD);
            dp_enable_r    <= (state_nxt_s == ST_COMPUTE);
            out_load_r     <= (state_nxt_s == ST_CAPTURE);
            out_shift_en_r <= (state_nxt_s == ST_UNLOAD);
            aborted_r      <= aborted_nxt_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign in_shift_en  = in_shift_en_r;
    assign dp_enable    = dp_enable_r;
    assign out_load     = out_load_r;
    assign out_shift_en = out_shift_en_r;
    assign phase        = state_r;

`ifdef SEQ_ABORT_EN
    assign aborted = aborted_r;
`else
    logic unused_aborted_s;
    assign unused_aborted_s = aborted_r ^ aborted_nxt_s;
`endif

endmodule

// File: tb/tb_serial_op_sequencer.sv
// tb_serial_op_sequencer
// Two sequencers (COMPUTE_CYCLES 1 and 3, DATA_WIDTH 8) share stimulus.
// A reference model tracks the cycle each frame was accepted and derives the
// expected phase from the offset into the frame using the phase lengths.
// A small serial adder built on the strobes of the first instance checks that
// the framing moves a complete operand pair through (0xA5 + 0x3C = 0xE1).
// Define SEQ_ABORT_EN to also exercise abort/aborted.

module tb_serial_op_sequencer;

    localparam int DW       = 8;
    localparam int CC_A     = 1;
    localparam int CC_B     = 3;
    localparam int NO_FRAME = -1000000;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       abort_in;

    logic       busy_a, done_a, ins_a, dpe_a, ol_a, os_a, abd_a;
    logic [2:0] ph_a;
    logic       busy_b, done_b, ins_b, dpe_b, ol_b, os_b, abd_b;
    logic [2:0] ph_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int frame_start[2];
    int aborted_at[2];

    serial_op_sequencer #(.DATA_WIDTH(DW), .COMPUTE_CYCLES(CC_A)) dut_a (
        .clk(clk), .resetn(resetn), .start(start),
`ifdef SEQ_ABORT_EN
        .abort(abort_in), .aborted(abd_a),
`endif
        .busy(busy_a), .done(done_a), .in_shift_en(ins_a), .dp_enable(dpe_a),
        .out_load(ol_a), .out_shift_en(os_a), .phase(ph_a)
    );

    serial_op_sequencer #(.DATA_WIDTH(DW), .COMPUTE_CYCLES(CC_B)) dut_b (
        .clk(clk), .resetn(resetn), .start(start),
`ifdef SEQ_ABORT_EN
        .abort(abort_in), .aborted(abd_b),
`endif
        .busy(busy_b), .done(done_b), .in_shift_en(ins_b), .dp_enable(dpe_b),
        .out_load(ol_b), .out_shift_en(os_b), .phase(ph_b)
    );

`ifndef SEQ_ABORT_EN
    assign abd_a = 1'b0;
    assign abd_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial datapath driven by the strobes of dut_a.
    logic [7:0] a_src, b_src, a_sh, b_sh, res_sh, rx;
    logic [8:0] sum_r;
    always @(posedge clk) begin
        if (start && (ph_a == 3'd0) && resetn) begin
            a_src <= 8'hA5;
            b_src <= 8'h3C;
        end
        if (ins_a) begin
            a_sh  <= {a_src[0], a_sh[7:1]};
            b_sh  <= {b_src[0], b_sh[7:1]};
            a_src <= {a_src[0], a_src[7:1]};
            b_src <= {b_src[0], b_src[7:1]};
        end
        if (dpe_a) sum_r <= {1'b0, a_sh} + {1'b0, b_sh};
        if (ol_a) res_sh <= sum_r[7:0];
        if (os_a) begin
            rx     <= {res_sh[0], rx[7:1]};
            res_sh <= {1'b0, res_sh[7:1]};
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Phase from the offset d into a frame: DW load cycles, cc compute
    // cycles, one capture cycle, DW unload cycles.
    function automatic int phase_of(input int d, input int cc);
        if (d >= 1 && d <= DW) return 1;
        if (d > DW && d <= DW + cc) return 2;
        if (d == DW + cc + 1) return 3;
        if (d > DW + cc + 1 && d <= 2 * DW + cc + 1) return 4;
        return 0;
    endfunction

    task automatic model_check(input logic st, input logic ab, input logic rn);
        int         cc, d, ph;
        logic       dn, abx;
        logic [2:0] o_ph;
        logic       o_busy, o_done, o_abd;
        logic [3:0] o_str, e_str;
        for (int i = 0; i < 2; i++) begin
            cc = (i == 0) ? CC_A : CC_B;
            if (i == 0) begin
                o_ph = ph_a; o_busy = busy_a; o_done = done_a; o_abd = abd_a;
                o_str = {ins_a, dpe_a, ol_a, os_a};
            end else begin
                o_ph = ph_b; o_busy = busy_b; o_done = done_b; o_abd = abd_b;
                o_str = {ins_b, dpe_b, ol_b, os_b};
            end
            if (!rn) begin
                ph = 0; dn = 1'b0; abx = 1'b0;
                frame_start[i] = NO_FRAME;
                aborted_at[i]  = -1;
            end else begin
                d   = cyc - frame_start[i];
                ph  = phase_of(d, cc);
                dn  = (d == 2 * DW + cc + 2);
                abx = (aborted_at[i] == cyc);
            end
            e_str = {ph == 1, ph == 2, ph == 3, ph == 4};
            chk($sformatf("dut%0d_phase", i), 8'(o_ph), 8'(ph));
            chk($sformatf("dut%0d_busy", i), 8'(o_busy), 8'(ph != 0));
            chk($sformatf("dut%0d_strobes", i), 8'(o_str), 8'(e_str));
            chk($sformatf("dut%0d_done", i), 8'(o_done), 8'(dn));
            chk($sformatf("dut%0d_aborted", i), 8'(o_abd), 8'(abx));
            if (rn) begin
                if (ab && ph != 0) begin
                    frame_start[i] = NO_FRAME;
                    aborted_at[i]  = cyc + 1;
                end else if (st && ph == 0) begin
                    frame_start[i] = cyc;
                end
            end
        end
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input logic st, input logic ab, input logic rn);
        start    = st;
        abort_in = ab;
        resetn   = rn;
        @(negedge clk);
        model_check(st, ab, rn);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        abort_in = 1'b0;
        frame_start[0] = NO_FRAME; frame_start[1] = NO_FRAME;
        aborted_at[0]  = -1;       aborted_at[1]  = -1;
        @(posedge clk);
        #1;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Scenario 1: nominal frame plus datapath result
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b1);
        chk("serial_result", rx, 8'hE1);
        chk("carry", 8'(sum_r[8]), 8'h00);

        // Scenario 2: start held high -> back-to-back frames
        for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);

        // Scenario 3: start pulses during a frame are ignored
        for (int i = 0; i < 25; i++) step((i == 0 || i == 4 || i == 12), 1'b0, 1'b1);

        // Scenario 4: reset mid-frame, then a clean frame
        for (int i = 0; i < 6; i++) step((i == 0), 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);

`ifdef SEQ_ABORT_EN
        // Scenario 6: abort in cycle 10 of a frame, and abort while idle
        for (int i = 0; i < 30; i++) step((i == 0), (i == 10 || i == 25), 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic st, ab, rn;
            st = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 63) != 0);
`ifdef SEQ_ABORT_EN
            ab = ($urandom_range(0, 19) == 0);
`else
            ab = 1'b0;
`endif
            step(st, ab, rn);
        end
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
